mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle main controller for the MIPS-lite datapath: PC, IR, GRF, ALU, EXT, NPC and DM.
- Decodes op/func from the IR and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Asserts per-state write enables and combinational mux selects.
- Supports a wait-state data memory through a ready handshake.

Parameters:
- DM_WAIT_MAX, 15: max consecutive MEM wait cycles before the sticky dm_timeout flag sets; 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- dm_ready  in  1  DM completes the current access this cycle
- pc_en  out  1  PC loads NPC output at the clock edge
- ir_en  out  1  IR loads IM output at the clock edge
- control_alu  out  4  ALU op select (const.v encodings)
- control_ext  out  4  EXT mode
- control_npc  out  4  NPC mode
- control_grf_WD  out  4  GRF write-data mux select
- control_grf_WA  out  4  GRF write-address mux select
- control_alu_data2  out  4  ALU operand-B mux select
- dm_ReadEn  out  1  DM read strobe
- dm_WriteEn  out  1  DM write strobe
- grf_WE  out  1  GRF write enable
- state  out  3  current state, for debug
- dm_timeout  out  1  sticky: a MEM wait exceeded DM_WAIT_MAX

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with all enables 0.
- Reset: state=FETCH, wait counter=0, dm_timeout=0. While reset is high, pc_en, ir_en, grf_WE, dm_ReadEn and dm_WriteEn are forced 0. Reset mid-instruction aborts it with no further writes.
- Selects: the six control_* selects are decoded combinationally from op/func in every state. Encodings and the supported set are ori, lui, lw, sw, beq, j, jal, jr, addu, subu. Any other op/func pair is UNKNOWN, with all selects 0.
- Enables: Moore, from state plus the latched instruction class. Each is high only in the states listed below, otherwise 0.
- FETCH:
  - ir_en=1; next state DECODE.
- DECODE:
  - j, jr: pc_en=1, npc=j/jr; next FETCH.
  - jal: pc_en=1, grf_WE=1 (WA=$31, WD=PC+4); next FETCH.
  - UNKNOWN: pc_en=1, npc=pc4, treated as nop; next FETCH.
  - All other supported instructions: next EXEC.
- EXEC:
  - beq: pc_en=1, npc=beq; next FETCH.
  - lw, sw: next MEM.
  - ori, lui, addu, subu: next WB.
- MEM:
  - dm_ReadEn (lw) or dm_WriteEn (sw) is held high until the cycle dm_ready=1.
  - sw with dm_ready=1: pc_en=1; next FETCH.
  - lw with dm_ready=1: next WB.
  - dm_ready=0: stay in MEM; the 8-bit wait counter increments, saturating at 255.
  - When the counter reaches DM_WAIT_MAX, dm_timeout sets. It clears only on reset. The controller keeps waiting.
  - The counter clears on leaving MEM.
- WB:
  - grf_WE=1, pc_en=1, npc=pc4; next FETCH.
- Latency with dm_ready tied 1: j/jr/jal/UNKNOWN 2 cycles, beq 3, ori/lui/addu/subu/sw 4, lw 5.
- Every instruction asserts pc_en exactly once, in its final state. At most one of grf_WE/dm_WriteEn is high per cycle.
- op/func must stay stable from DECODE until the next FETCH; the IR guarantees this.

Optional Feature:
- Macro: MC_CONTROL_PERF_EN.
- When defined, adds ports cycle_cnt (out, 32) and instr_cnt (out, 32). Both reset to 0 on reset and wrap modulo 2^32.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each cycle with pc_en=1.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then ori: reset held 2 cycles, released; state sequence 0,1,2,4,0. ir_en high only in cycle 0. grf_WE and pc_en high only in WB. Selects equal the ori encodings.
- lw with dm_ready low 3 cycles, then high: MEM lasts 4 cycles with dm_ReadEn high all 4. Then WB with grf_WE=1. Total 8 cycles; dm_timeout stays 0.
- sw with DM_WAIT_MAX=2 and dm_ready low 5 cycles: dm_timeout rises after the 2nd wait cycle and stays 1 after sw completes. dm_WriteEn never overlaps grf_WE.
- beq, j, jal, jr back to back with dm_ready=1: lengths 3,2,2,2 cycles. grf_WE=1 only in the jal DECODE cycle. control_npc matches each type when pc_en=1.
- Unknown op 6'b111111, then addu: unknown completes in 2 cycles with pc_en=1 and no grf_WE/dm strobes. addu follows in 4 cycles.
- Reset asserted during lw MEM wait: the next edge gives state=0, all enables 0, dm_timeout=0. With MC_CONTROL_PERF_EN defined, cycle_cnt=instr_cnt=0.

Source files
------------

// File: rtl/mc_control_if.sv
// mc_control_if: IR fields, DM handshake and control outputs between mc_control (master) and the datapath (slave)
interface mc_control_if;
  logic [5:0] op, func;
  logic dm_ready, pc_en, ir_en, dm_ReadEn, dm_WriteEn, grf_WE, dm_timeout;
  logic [3:0] control_alu, control_ext, control_npc, control_grf_WD, control_grf_WA, control_alu_data2;
  logic [2:0] state;
  modport master(
    input op, func, dm_ready,
    output pc_en, ir_en, dm_ReadEn, dm_WriteEn, grf_WE, dm_timeout, state,
    output control_alu, control_ext, control_npc, control_grf_WD, control_grf_WA, control_alu_data2
  );
  modport slave(
    output op, func, dm_ready,
    input pc_en, ir_en, dm_ReadEn, dm_WriteEn, grf_WE, dm_timeout, state,
    input control_alu, control_ext, control_npc, control_grf_WD, control_grf_WA, control_alu_data2
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-lite controller with DM wait-state handshake; MC_CONTROL_PERF_EN adds cycle/instruction counters
module mc_control #(
  parameter int DM_WAIT_MAX = 15
) (
  input logic clk,
  input logic reset,
  mc_control_if.master bus
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  localparam logic [3:0] C_UNK = 4'd0, C_ORI = 4'd1, C_LUI = 4'd2, C_LW = 4'd3, C_SW = 4'd4, C_BEQ = 4'd5,
                         C_J = 4'd6, C_JAL = 4'd7, C_JR = 4'd8, C_ADDU = 4'd9, C_SUBU = 4'd10;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0d,
                         OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2;
  localparam logic [3:0] EXT_ZERO = 4'd0, EXT_SIGN = 4'd1, EXT_LUI = 4'd2;
  localparam logic [3:0] NPC_PC4 = 4'd0, NPC_BEQ = 4'd1, NPC_J = 4'd2, NPC_JR = 4'd3;
  localparam logic [3:0] WD_ALU = 4'd0, WD_DM = 4'd1, WD_PC4 = 4'd2;
  localparam logic [3:0] WA_RT = 4'd0, WA_RD = 4'd1, WA_31 = 4'd2;
  localparam logic [3:0] B_GRF = 4'd0, B_EXT = 4'd1;
  localparam logic [7:0] WAIT_MAX = 8'(DM_WAIT_MAX);
  logic [2:0] state, nxt;
  logic [3:0] cls_dec, cls_q;
  logic [23:0] sel;
  logic [7:0] wait_cnt, wait_inc;
  logic timeout_q, waiting;
  logic pc_en_n, ir_en_n, we_n, rd_n, wr_n;
  // {alu, ext, npc, grf_WD, grf_WA, alu_data2}; unsupported op/func leaves everything 0
  always_comb begin
    cls_dec = C_UNK;
    sel = '0;
    case (bus.op)
      OP_ORI: begin cls_dec = C_ORI; sel = {ALU_OR, EXT_ZERO, NPC_PC4, WD_ALU, WA_RT, B_EXT}; end
      OP_LUI: begin cls_dec = C_LUI; sel = {ALU_OR, EXT_LUI, NPC_PC4, WD_ALU, WA_RT, B_EXT}; end
      OP_LW:  begin cls_dec = C_LW;  sel = {ALU_ADD, EXT_SIGN, NPC_PC4, WD_DM, WA_RT, B_EXT}; end
      OP_SW:  begin cls_dec = C_SW;  sel = {ALU_ADD, EXT_SIGN, NPC_PC4, WD_ALU, WA_RT, B_EXT}; end
      OP_BEQ: begin cls_dec = C_BEQ; sel = {ALU_SUB, EXT_SIGN, NPC_BEQ, WD_ALU, WA_RT, B_GRF}; end
      OP_J:   begin cls_dec = C_J;   sel = {ALU_ADD, EXT_ZERO, NPC_J, WD_ALU, WA_RT, B_GRF}; end
      OP_JAL: begin cls_dec = C_JAL; sel = {ALU_ADD, EXT_ZERO, NPC_J, WD_PC4, WA_31, B_GRF}; end
      OP_R:
        case (bus.func)
          F_JR:   begin cls_dec = C_JR;   sel = {ALU_ADD, EXT_ZERO, NPC_JR, WD_ALU, WA_RT, B_GRF}; end
          F_ADDU: begin cls_dec = C_ADDU; sel = {ALU_ADD, EXT_ZERO, NPC_PC4, WD_ALU, WA_RD, B_GRF}; end
          F_SUBU: begin cls_dec = C_SUBU; sel = {ALU_SUB, EXT_ZERO, NPC_PC4, WD_ALU, WA_RD, B_GRF}; end
          default: ;
        endcase
      default: ;
    endcase
  end
  assign {bus.control_alu, bus.control_ext, bus.control_npc, bus.control_grf_WD, bus.control_grf_WA, bus.control_alu_data2} = sel;
  always_comb begin
    nxt = S_FETCH;
    pc_en_n = 1'b0;
    ir_en_n = 1'b0;
    we_n = 1'b0;
    rd_n = 1'b0;
    wr_n = 1'b0;
    case (state)
      S_FETCH: begin
        ir_en_n = 1'b1;
        nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_en_n = cls_dec == C_J || cls_dec == C_JR || cls_dec == C_JAL || cls_dec == C_UNK;
        we_n = cls_dec == C_JAL;
        nxt = pc_en_n ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        pc_en_n = cls_q == C_BEQ;
        nxt = pc_en_n ? S_FETCH : (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        rd_n = cls_q == C_LW;
        wr_n = cls_q == C_SW;
        pc_en_n = bus.dm_ready && cls_q == C_SW;
        nxt = !bus.dm_ready ? S_MEM : cls_q == C_LW ? S_WB : S_FETCH;
      end
      S_WB: begin
        we_n = 1'b1;
        pc_en_n = 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.pc_en = pc_en_n && !reset;
  assign bus.ir_en = ir_en_n && !reset;
  assign bus.grf_WE = we_n && !reset;
  assign bus.dm_ReadEn = rd_n && !reset;
  assign bus.dm_WriteEn = wr_n && !reset;
  assign bus.state = state;
  assign bus.dm_timeout = timeout_q;
  assign waiting = state == S_MEM && !bus.dm_ready;
  assign wait_inc = wait_cnt + {7'd0, wait_cnt != 8'hff};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cls_q <= C_UNK;
      wait_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= cls_dec;
      wait_cnt <= waiting ? wait_inc : 8'd0;
      if (waiting && wait_inc >= WAIT_MAX) timeout_q <= 1'b1;
    end
  end
`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      instr_cnt <= instr_cnt + {31'd0, bus.pc_en};
    end
  end
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream against a latency/strobe reference model with a pc_en-driven scoreboard
module tb_mc_control;
  localparam int WMAX = 2;
  localparam int K_ORI = 0, K_LUI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_JAL = 6, K_JR = 7,
                 K_ADDU = 8, K_SUBU = 9, K_UNK = 10;
  typedef struct {
    int lat, we, rd, wr;
    logic [23:0] sel;
    logic tmo;
    logic [95:0] sts;
  } exp_t;
  logic clk, reset;
  mc_control_if bus();
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
  mc_control #(.DM_WAIT_MAX(WMAX)) dut (.clk(clk), .reset(reset), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
  mc_control #(.DM_WAIT_MAX(WMAX)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  exp_t q[$];
  int checks = 0, failures = 0;
  int phase_instr, phase_cycles;
  logic sticky;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] sel_of(input int c);
    case (c)
      K_ORI:  return {4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
      K_LUI:  return {4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1};
      K_LW:   return {4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
      K_SW:   return {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
      K_BEQ:  return {4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
      K_J:    return {4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
      K_JAL:  return {4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0};
      K_JR:   return {4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0};
      K_ADDU: return {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      K_SUBU: return {4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      default: return 24'd0;
    endcase
  endfunction
  task automatic chk_idle(input string nm);
    chk(nm, {bus.pc_en, bus.ir_en, bus.grf_WE, bus.dm_ReadEn, bus.dm_WriteEn}, 0);
  endtask
  // entered and left at posedge+1; on exit the first post-reset FETCH cycle has begun
  task automatic apply_reset();
    reset = 1'b1;
    bus.dm_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset_state", bus.state, 0);
    chk("reset_timeout", bus.dm_timeout, 0);
    chk_idle("reset_enables");
`ifdef MC_CONTROL_PERF_EN
    chk("reset_perf", {cycle_cnt, instr_cnt}, 0);
`endif
    q.delete();
    sticky = 1'b0;
    phase_instr = 0;
    phase_cycles = 0;
    reset = 1'b0;
  endtask
  task automatic run_instr(input int c, input int k);
    exp_t e;
    logic [5:0] op, fn;
    int n;
    bit mem, alu, jmp;
    fn = 6'($urandom);
    case (c)
      K_ORI: op = 6'h0d;
      K_LUI: op = 6'h0f;
      K_LW: op = 6'h23;
      K_SW: op = 6'h2b;
      K_BEQ: op = 6'h04;
      K_J: op = 6'h02;
      K_JAL: op = 6'h03;
      K_JR: begin op = 6'h00; fn = 6'h08; end
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      default:
        case ($urandom_range(0, 4))
          0: op = 6'h3f;
          1: op = 6'h01;
          2: op = 6'h0e;
          3: begin op = 6'h00; fn = 6'h20; end
          default: begin op = 6'h00; fn = 6'h00; end
        endcase
    endcase
    bus.op = op;
    bus.func = fn;
    mem = c == K_LW || c == K_SW;
    alu = c == K_ORI || c == K_LUI || c == K_ADDU || c == K_SUBU;
    jmp = c == K_J || c == K_JR || c == K_JAL || c == K_UNK;
    e.lat = jmp ? 2 : c == K_BEQ ? 3 : alu ? 4 : c == K_SW ? 4 + k : 5 + k;
    e.we = (alu || c == K_LW || c == K_JAL) ? 1 : 0;
    e.rd = c == K_LW ? k + 1 : 0;
    e.wr = c == K_SW ? k + 1 : 0;
    e.sel = sel_of(c);
    if (mem && k >= WMAX) sticky = 1'b1;
    e.tmo = sticky;
    e.sts = '0;
    e.sts[5:3] = 3'd1;
    n = 2;
    if (!jmp) begin e.sts[3*n +: 3] = 3'd2; n++; end
    if (mem) for (int i = 0; i <= k; i++) begin e.sts[3*n +: 3] = 3'd3; n++; end
    if (alu || c == K_LW) e.sts[3*n +: 3] = 3'd4;
    q.push_back(e);
    phase_instr++;
    phase_cycles += e.lat;
    for (int i = 0; i < e.lat; i++) begin
      bus.dm_ready = i >= 3 + k;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic end_phase();
    chk("drain", q.size(), 0);
`ifdef MC_CONTROL_PERF_EN
    chk("perf_counts", {cycle_cnt, instr_cnt}, {32'(phase_cycles), 32'(phase_instr)});
`endif
  endtask
  // scoreboard: accumulate per-instruction observations, compare on each pc_en
  initial begin
    int cyc, we, rd, wr, ir;
    logic ovl;
    logic [95:0] obs;
    exp_t e;
    cyc = 0; we = 0; rd = 0; wr = 0; ir = 0; ovl = 0; obs = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        cyc = 0; we = 0; rd = 0; wr = 0; ir = 0; ovl = 0; obs = '0;
      end else begin
        if (cyc < 32) obs[3*cyc +: 3] = bus.state;
        cyc++;
        we += int'(bus.grf_WE);
        rd += int'(bus.dm_ReadEn);
        wr += int'(bus.dm_WriteEn);
        ir += int'(bus.ir_en);
        ovl |= bus.grf_WE & bus.dm_WriteEn;
        if (bus.pc_en === 1'b1) begin
          chk("pc_en_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("latency", cyc, e.lat);
            chk("states", obs, e.sts);
            chk("grf_we_cycles", we, e.we);
            chk("dm_read_cycles", rd, e.rd);
            chk("dm_write_cycles", wr, e.wr);
            chk("ir_en_cycles", ir, 1);
            chk("we_wr_overlap", ovl, 0);
            chk("selects", {bus.control_alu, bus.control_ext, bus.control_npc, bus.control_grf_WD,
                            bus.control_grf_WA, bus.control_alu_data2}, e.sel);
            chk("dm_timeout", bus.dm_timeout, e.tmo);
          end
          cyc = 0; we = 0; rd = 0; wr = 0; ir = 0; ovl = 0; obs = '0;
        end
      end
    end
  end
  initial begin
    int c;
    reset = 1'b1;
    bus.op = 6'h00;
    bus.func = 6'h00;
    bus.dm_ready = 1'b0;
    sticky = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    run_instr(K_ORI, 0);
    run_instr(K_LW, 1);
    run_instr(K_BEQ, 0);
    run_instr(K_J, 0);
    run_instr(K_JAL, 0);
    run_instr(K_JR, 0);
    run_instr(K_UNK, 0);
    run_instr(K_ADDU, 0);
    run_instr(K_SUBU, 0);
    run_instr(K_LUI, 0);
    run_instr(K_SW, 5);
    run_instr(K_LW, 0);
    end_phase();
    for (int p = 0; p < 3; p++) begin
      apply_reset();
      for (int i = 0; i < 25; i++) begin
        c = $urandom_range(0, 10);
        run_instr(c, $urandom_range(0, 3));
      end
      end_phase();
    end
    // abort a lw stalled in MEM after two wait cycles
    apply_reset();
    bus.op = 6'h23;
    bus.func = 6'($urandom);
    bus.dm_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("abort_state_before", bus.state, 3);
    chk("abort_timeout_before", bus.dm_timeout, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort_enables_in_reset");
    @(posedge clk);
    #1;
    chk("abort_state_after", bus.state, 0);
    chk("abort_timeout_after", bus.dm_timeout, 0);
    chk_idle("abort_enables_after");
`ifdef MC_CONTROL_PERF_EN
    chk("abort_perf", {cycle_cnt, instr_cnt}, 0);
`endif
    q.delete();
    sticky = 1'b0;
    phase_instr = 0;
    phase_cycles = 0;
    reset = 1'b0;
    run_instr(K_ORI, 0);
    run_instr(K_SW, 0);
    end_phase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
